// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, line levels and bit-timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line conditioning: 2-flop synchroniser, previous-sample flop and falling-edge detect.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RST_VAL = UART_IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default with a valid/ready output; define UART_RX_PARITY_EN
// to add a parity bit (PARITY_ODD selects odd parity) and the o_rx_parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_WIDTH = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_serial,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_rx_frame_err,
  output logic                  o_rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  o_rx_parity_err
`endif
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  w_rx_s;
  logic                  w_fall;
  logic                  w_bit_end;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bit;
  logic                  r_parity_err;
`endif

  uart_rx_sync #(
    .RST_VAL(UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .i_rx  (i_rx_serial),
    .o_rx_s(w_rx_s),
    .o_fall(w_fall)
  );

  assign w_bit_end = (r_cnt == FULL_CNT);

  // Frame FSM; every state change clears the bit-timing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_valid && i_rx_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= (w_rx_s == UART_START_LEVEL) ? DATA : IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_rx_s == UART_IDLE_LEVEL) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              if (r_valid && !i_rx_ready) r_overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= ((^r_shift) ^ r_par_bit) != PARITY_ODD;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_rx_data      = r_data;
  assign o_rx_valid     = r_valid;
  assign o_rx_frame_err = r_frame_err;
  assign o_rx_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_rx_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: behavioural serial transmitter, expected-event queue and monitor.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 320;
  localparam int unsigned BAUD_RATE = 10;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DW        = 8;
  localparam logic        PODD      = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          w_perr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            fe;
    logic [DW-1:0] d;
    bit            ovr;
    bit            perr;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DW),
    .PARITY_ODD(PODD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_serial    (rx_serial),
    .o_rx_data      (rx_data),
    .o_rx_valid     (rx_valid),
    .i_rx_ready     (rx_ready),
    .o_rx_frame_err (rx_frame_err),
    .o_rx_overrun   (rx_overrun),
    .o_rx_parity_err(w_perr)
  );
`else
  assign w_perr = 1'b0;
  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_rx_serial   (rx_serial),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_rx_frame_err(rx_frame_err),
    .o_rx_overrun  (rx_overrun)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_line(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame with bit period p; optionally queue the response the receiver owes us.
  task automatic frame(input logic [DW-1:0] d, input int p, input bit stop_ok,
                       input bit bad_par, input bit ovr, input bit push);
    logic pb;
    exp_t e;
    pb = (^d) ^ PODD ^ bad_par;
    if (!stop_ok) e = '{fe: 1'b1, d: '0, ovr: 1'b0, perr: 1'b0};
    else e = '{fe: 1'b0, d: d, ovr: ovr, perr: PAR_EN && (((^d) ^ pb) != PODD)};
    if (push) sbq.push_back(e);
    hold_line(1'b0, p);
    for (int i = 0; i < DW; i++) hold_line(d[i], p);
`ifdef UART_RX_PARITY_EN
    hold_line(pb, p);
`endif
    hold_line(stop_ok, p);
    rx_serial = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  // Monitor: every word / error event the DUT presents must match the head of the queue.
  initial begin : monitor
    bit   pv;
    bit   pacc;
    bit   word;
    exp_t e;
    pv   = 1'b0;
    pacc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv   = 1'b0;
        pacc = 1'b0;
        continue;
      end
      word = rx_valid && (!pv || pacc || rx_overrun);
      if (rx_frame_err) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_err: got pulse expected none");
        end else begin
          e = sbq.pop_front();
          chk("event_is_frame_err", 32'(rx_frame_err), 32'(e.fe));
        end
      end
      if (word) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data %0h expected no word", rx_data);
        end else begin
          e = sbq.pop_front();
          chk("event_is_word", 32'(!e.fe), 32'(1));
          chk("rx_data", 32'(rx_data), 32'(e.d));
          chk("rx_overrun", 32'(rx_overrun), 32'(e.ovr));
          chk("rx_parity_err", 32'(w_perr), 32'(e.perr));
        end
      end else begin
        if (rx_overrun) chk("stray_overrun", 32'(rx_overrun), 32'(0));
        if (w_perr) chk("stray_parity_err", 32'(w_perr), 32'(0));
      end
      pv   = rx_valid;
      pacc = rx_valid && rx_ready;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] d;
    int            p;
    int            gap;
    bit            stop_ok;
    bit            bad;

    @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 32'(0));
    chk("reset_data", 32'(rx_data), 32'(0));
    chk("reset_frame_err", 32'(rx_frame_err), 32'(0));
    chk("reset_overrun", 32'(rx_overrun), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    hold_line(1'b1, 2 * CPB);

    // Plain loopback at the transmitter's slow bit period
    frame(8'hA5, CPB + 1, 1, 0, 0, 1);
    wait_drain("t1_drain", 4 * CPB);
    hold_line(1'b1, CPB);

    // Short low glitch is a false start
    hold_line(1'b0, CPB / 4);
    hold_line(1'b1, 2 * CPB);
    frame(8'h3C, CPB + 1, 1, 0, 0, 1);
    wait_drain("t2_drain", 4 * CPB);

    // Bad stop bit, then recovery
    frame(8'h55, CPB + 1, 0, 0, 0, 1);
    hold_line(1'b1, CPB);
    chk("t3_valid_after_fe", 32'(rx_valid), 32'(0));
    frame(8'h0F, CPB + 1, 1, 0, 0, 1);
    wait_drain("t3_drain", 4 * CPB);

    // Overrun with the consumer stalled
    rx_ready = 1'b0;
    frame(8'h11, CPB + 1, 1, 0, 0, 1);
    hold_line(1'b1, CPB);
    frame(8'h22, CPB + 1, 1, 0, 1, 1);
    wait_drain("t4_drain", 4 * CPB);
    chk("t4_valid_held", 32'(rx_valid), 32'(1));
    chk("t4_data_last", 32'(rx_data), 32'(8'h22));
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_before_accept", 32'(rx_valid), 32'(1));
    @(negedge clk);
    chk("t4_valid_dropped", 32'(rx_valid), 32'(0));
    @(posedge clk);
    #1;

    // Reset in mid-DATA abandons the frame and clears a held word
    rx_ready = 1'b0;
    frame(8'h5A, CPB + 1, 1, 0, 0, 1);
    wait_drain("t5_pre_drain", 4 * CPB);
    hold_line(1'b1, CPB);
    fork
      frame(8'hFF, CPB + 1, 1, 0, 0, 0);
      begin
        repeat (CPB * 5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(rx_valid), 32'(0));
        chk("t5_rst_data", 32'(rx_data), 32'(0));
        chk("t5_rst_frame_err", 32'(rx_frame_err), 32'(0));
        chk("t5_rst_overrun", 32'(rx_overrun), 32'(0));
      end
    join
    rx_ready = 1'b1;
    hold_line(1'b1, 2 * CPB);
    frame(8'h81, CPB + 1, 1, 0, 0, 1);
    wait_drain("t5_drain", 4 * CPB);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 needs parity bit 1, so a 0 bit is an error
    frame(8'h07, CPB + 1, 1, 1, 0, 1);
    wait_drain("t6_bad_drain", 4 * CPB);
    frame(8'h07, CPB + 1, 1, 0, 0, 1);
    wait_drain("t6_good_drain", 4 * CPB);
`endif

    // Random frames: data, bit period drift, gaps, stop and parity faults
    for (int k = 0; k < 24; k++) begin
      d       = DW'($urandom_range(0, 255));
      p       = int'($urandom_range(CPB - 1, CPB + 1));
      stop_ok = ($urandom_range(0, 9) != 0);
      bad     = PAR_EN && ($urandom_range(0, 1) == 1);
      frame(d, p, stop_ok, bad, 0, 1);
      gap = int'($urandom_range(stop_ok ? 0 : 4, 3 * CPB));
      if (gap > 0) hold_line(1'b1, gap);
    end
    wait_drain("random_drain", 4 * CPB);

    hold_line(1'b1, 2 * CPB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver. It is the downstream stage that consumes the `tx_serial` line produced by the team's UART transmitter.
- Data framing is 8N1 by default: start bit (0), DATA_WIDTH data bits LSB-first, stop bit (1).
- The receiver synchronises the asynchronous line, detects the start edge and samples each bit at its midpoint.
- Each received word is presented on a valid/ready interface to the consuming logic.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 1041 at defaults).
- DATA_WIDTH, 8, data bits per frame (5..9).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_data  out  DATA_WIDTH  received word; valid while rx_valid=1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- rx_overrun  out  1  one-cycle pulse: new word completed while rx_valid still high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0.
  - Counters cleared.
  - Synchroniser flops set to 1.
  - Reset mid-frame abandons the frame; no output pulses follow.
- Input conditioning:
  - 2-flop synchroniser on rx_serial gives rx_s.
  - Previous-sample flop gives rx_q.
  - Falling edge is defined as rx_q=1 & rx_s=0.
- Clock counter: 0..CLKS_PER_BIT-1; cleared on every state change.
- State machine states: IDLE, START, DATA, STOP.
  - IDLE: on falling edge → START, counter=0.
  - START: at counter = CLKS_PER_BIT/2 - 1 (mid start bit), sample rx_s.
    - 0 → DATA, bit_idx=0.
    - 1 → false start, return to IDLE, no outputs.
  - DATA: every CLKS_PER_BIT clocks (mid-bit), shift rx_s into the shift register MSB; data ends up LSB-first aligned.
    - bit_idx increments after each sample.
    - After sample DATA_WIDTH-1 → STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample rx_s.
    - 1 → load rx_data from the shift register, set rx_valid.
    - 0 → pulse rx_frame_err; rx_data and rx_valid unchanged.
    - Both cases → IDLE the next cycle.
    - Re-arm needs a fresh falling edge, so a held-low break never produces repeated frames.
- Sample-point tolerance:
  - The transmitter's bit period is CLKS_PER_BIT+1 clocks. Cumulative drift over 10 bits is ≤10 clocks, well inside the ±CLKS_PER_BIT/2 margin.
  - Returning to IDLE at mid-stop guarantees the next start edge is caught.
- Handshake:
  - rx_valid clears the cycle after rx_valid & rx_ready.
  - A new word completing in the same cycle as acceptance: rx_valid stays 1, rx_data updates, no overrun.
  - A new word completing while rx_valid=1 and rx_ready=0: rx_data overwritten, rx_valid stays 1, rx_overrun pulses once.
- Latency: rx_valid rises 1 clk after the stop-bit sample edge, ≈9.5 bit periods (+ 3 sync clocks) after the start edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled at mid-bit.
  - Adds output port rx_parity_err (1 bit).
  - On a parity mismatch with a good stop bit: rx_data/rx_valid update normally, and rx_parity_err pulses in the same cycle that rx_valid is set.
  - A framing error takes precedence: only rx_frame_err pulses.
- When undefined: no PARITY state and no rx_parity_err port; 8N1 framing only.

Decomposition:
- Package uart_pkg contains:
  - state enum uart_state_e (IDLE, START, DATA, STOP, PARITY).
  - function clks_per_bit(clk_freq, baud).
  - constants UART_IDLE_LEVEL=1 and UART_START_LEVEL=0.
- The transmitter is to be migrated to uart_pkg as well.
- Sub-module uart_rx_sync:
  - Contains the 2-flop synchroniser, previous-sample flop and falling-edge detect.
  - Parameter: reset value 1.
  - Outputs: rx_s, fall.

Test Plan:
1. Loopback from the team's transmitter, tx_data=8'hA5, rx_ready=1 → one rx_valid pulse with rx_data=8'hA5; rx_frame_err=0, rx_overrun=0.
2. Line low for 300 clks, then high → false start; no rx_valid and no rx_frame_err; the following frame 8'h3C is received correctly.
3. Frame 8'h55 with the stop bit driven 0 for a full bit period → rx_frame_err pulses 1 cycle, rx_valid stays 0; the next frame 8'h0F is received after the line returns high.
4. rx_ready=0, frames 8'h11 then 8'h22 → rx_valid held, rx_data=8'h22, one rx_overrun pulse; setting rx_ready=1 drops rx_valid the next cycle.
5. rst asserted at mid-DATA of frame 8'hFF → outputs zero; no valid or error pulses; the next frame 8'h81 is received correctly.
6. (UART_RX_PARITY_EN, even parity) frame 8'h07 with parity bit 0 → rx_valid with rx_data=8'h07 and rx_parity_err pulses; the same frame with parity bit 1 → no rx_parity_err.
